program_rom_server: RTL and testbench
=====================================

// Module: program_rom_server
// PURPOSE
//   Instruction-memory responder for the cpu fetch port: returns rom_data for the cpu's rom_address.
//   Before the cpu runs, it fills its word store from a byte stream (UART receiver side, valid/ready).
//   Holds cpu_enable low until a complete, valid image has been loaded.
//   Sits at board top level between the byte receiver and cpu (rom_address/rom_data/enable).
// PARAMETERS
//   ADDR_BITS   8              word-index width; store holds 2**ADDR_BITS 32-bit words
//   NOP_WORD    32'h00000013   word returned for unloaded/out-of-range fetches (addi x0,x0,0)
// PORTS
//   clock         in   1            single clock, all state updates on posedge
//   reset         in   1            asynchronous, active-high; returns FSM to LEN_LO
//   rx_valid      in   1            byte-stream data valid
//   rx_data       in   8            byte-stream data
//   rx_ready      out  1            block accepts a byte this cycle
//   rom_address   in   32           cpu fetch byte address
//   rom_data      out  32           fetched instruction word, registered
//   cpu_enable    out  1            1 = image loaded, cpu may clock
//   loaded_words  out  ADDR_BITS+1  words written so far in the current load
//   load_error    out  1            declared length exceeded capacity
// BEHAVIOUR
//   Reset values: FSM=LEN_LO, rx_ready=1, rom_data=NOP_WORD, cpu_enable=0, loaded_words=0, load_error=0.
//   Store contents are not cleared by reset; validity comes from loaded_words only.
//   Byte transfer happens on a rising edge where rx_valid && rx_ready. No transfer when rx_valid=0.
//   Stream format: word count N (2 bytes, little-endian), then N words of 4 bytes each, little-endian.
//   FSM states:
//     LEN_LO: transfer -> N[7:0]; next state LEN_HI.
//     LEN_HI: transfer -> N[15:8].
//       N == 0 -> RUN.
//       N > 2**ADDR_BITS -> ERROR.
//       otherwise -> DATA, byte_idx=0.
//     DATA: each transfer shifts into word byte byte_idx; byte_idx increments mod 4.
//       On byte_idx==3 the word is written to store[loaded_words] and loaded_words increments.
//       When the increment makes loaded_words==N -> RUN on that same edge.
//     RUN: rx_ready=0, stream bytes are ignored, cpu_enable=1. Stays in RUN until reset.
//     ERROR: rx_ready=0, load_error=1, cpu_enable=0. Stays in ERROR until reset.
//   rx_ready = 1 in LEN_LO, LEN_HI and DATA only.
//   cpu_enable and load_error are decoded from the registered state, so they change the cycle after the transition edge.
//   Fetch read, one-cycle latency: on each posedge, rom_data <= f(rom_address sampled at that edge).
//     idx = rom_address[ADDR_BITS+1:2]; rom_address[1:0] is ignored.
//     rom_address[31:ADDR_BITS+2] != 0 -> NOP_WORD.
//     idx >= loaded_words -> NOP_WORD.
//     state != RUN -> NOP_WORD.
//     otherwise -> store[idx].
//   In RUN, loaded_words == N, so fetches past the end of the image return NOP.
//   A DATA write and a fetch in the same cycle cannot occur: fetch returns data only in RUN.
//   Reset mid-load: immediate return to LEN_LO with loaded_words=0; the partial word is discarded; the host must resend the whole image.
//   Reset mid-run: cpu_enable drops asynchronously; the next image overwrites the store from index 0.
// TESTING
//   1. Reset, stream 02 00 | 13 05 10 00 | 93 05 20 00 ->
//      store[0]=32'h00100513, store[1]=32'h00200593; cpu_enable=1 one cycle after the last byte.
//      rom_address=0 -> rom_data=32'h00100513 next cycle; rom_address=4 -> 32'h00200593.
//   2. After test 1: rom_address=8 -> NOP_WORD. rom_address=32'h00001000 (ADDR_BITS=8) -> NOP_WORD.
//      rom_address=5 -> 32'h00200593 (low bits ignored).
//   3. Stream 01 01 (N=257, ADDR_BITS=8) -> ERROR state: load_error=1, rx_ready=0, cpu_enable=0.
//      Further bytes are not accepted. Reset clears load_error.
//   4. Stream 00 00 -> RUN immediately, cpu_enable=1, every fetch returns NOP_WORD.
//   5. Stream 01 00 AA BB then assert reset, then stream 01 00 13 00 00 00 ->
//      loaded_words=1, store[0]=32'h00000013; the partial 0xBBAA is never visible on rom_data.
//   6. Gap rx_valid low between every byte, and hold rx_valid high in RUN ->
//      identical store contents as the back-to-back case; no bytes accepted in RUN; loaded_words stays N.

Source files
------------

// File: rtl/program_rom_server_if.sv
// Byte-stream loader and cpu fetch bundle for program_rom_server.
// The slave modport is the server; the master modport is the board side (receiver + cpu).
interface program_rom_server_if #(
  parameter int unsigned ADDR_BITS = 8
);
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic [31:0]          rom_address;
  logic [31:0]          rom_data;
  logic                 cpu_enable;
  logic [ADDR_BITS:0]   loaded_words;
  logic                 load_error;

  modport slave (
    input  rx_valid, rx_data, rom_address,
    output rx_ready, rom_data, cpu_enable, loaded_words, load_error
  );

  modport master (
    output rx_valid, rx_data, rom_address,
    input  rx_ready, rom_data, cpu_enable, loaded_words, load_error
  );
endinterface

// File: rtl/program_rom_server.sv
// Instruction ROM for the cpu fetch port, filled from a length-prefixed little-endian byte stream.
// cpu_enable is held low until the declared number of words has been stored.
module program_rom_server #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic                  clock,
  input  logic                  reset,
  program_rom_server_if.slave   bus
);

  localparam logic [2:0] ST_LEN_LO = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [16:0] CAP   = 17'(DEPTH);

  logic [2:0]           state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [23:0]          word_q, word_d;
  logic [ADDR_BITS:0]   loaded_q, loaded_d;
  logic [31:0]          rom_data_q, rom_data_d;
  logic [31:0]          store [DEPTH];

  logic                 rx_ready;
  logic                 xfer;
  logic                 we;
  logic [15:0]          len_full;
  logic [ADDR_BITS-1:0] fetch_idx;
  logic                 fetch_hi_nz;

  assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign xfer     = bus.rx_valid && rx_ready;
  assign len_full = {bus.rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    loaded_d   = loaded_q;
    we         = 1'b0;
    case (state_q)
      ST_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.rx_data;
          byte_idx_d  = 2'd0;
          if (len_full == 16'd0)
            state_d = ST_RUN;
          else if ({1'b0, len_full} > CAP)
            state_d = ST_ERROR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              we       = 1'b1;
              loaded_d = loaded_q + 1'b1;
              if (17'(loaded_d) == {1'b0, len_q})
                state_d = ST_RUN;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign fetch_idx   = bus.rom_address[ADDR_BITS+1:2];
  assign fetch_hi_nz = |bus.rom_address[31:ADDR_BITS+2];

  always_comb begin
    rom_data_d = NOP_WORD;
    if (state_q == ST_RUN && !fetch_hi_nz && {1'b0, fetch_idx} < loaded_q)
      rom_data_d = store[fetch_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LEN_LO;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      loaded_q   <= '0;
      rom_data_q <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      loaded_q   <= loaded_d;
      rom_data_q <= rom_data_d;
    end
  end

  // Store is deliberately unreset: only loaded_words decides which entries are valid.
  always_ff @(posedge clock) begin
    if (we)
      store[loaded_q[ADDR_BITS-1:0]] <= {bus.rx_data, word_q};
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.rom_data     = rom_data_q;
  assign bus.cpu_enable   = (state_q == ST_RUN);
  assign bus.load_error   = (state_q == ST_ERROR);
  assign bus.loaded_words = loaded_q;

endmodule

// File: tb/tb_program_rom_server.sv
// Randomized bench for program_rom_server against a byte-count based model of the load protocol.
module tb_program_rom_server;

  localparam int unsigned ADDR_BITS = 8;
  localparam int          CAP       = 256;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  program_rom_server_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  program_rom_server #(.ADDR_BITS(ADDR_BITS), .NOP_WORD(NOP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: everything follows from how many bytes have been accepted since reset.
  int          m_cnt;
  int          m_n;
  logic [7:0]  m_lo;
  logic [31:0] m_store [CAP];
  logic [31:0] exp_rom;

  function automatic int m_loaded();
    int d;
    if (m_n < 0 || m_n > CAP) return 0;
    d = (m_cnt - 2) / 4;
    return (d > m_n) ? m_n : d;
  endfunction

  function automatic bit m_run();
    return (m_n >= 0) && (m_n <= CAP) && (m_loaded() == m_n);
  endfunction

  function automatic bit m_err();
    return m_n > CAP;
  endfunction

  function automatic bit m_ready();
    return !m_run() && !m_err();
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    int idx;
    idx = int'(a[9:2]);
    if (m_run() && a[31:10] == '0 && idx < m_loaded()) return m_store[idx];
    return NOP;
  endfunction

  task automatic m_accept(input logic [7:0] b);
    int p;
    if (m_cnt == 0) m_lo = b;
    else if (m_cnt == 1) m_n = int'({b, m_lo});
    else begin
      p = m_cnt - 2;
      m_store[p / 4][8 * (p % 4) +: 8] = b;
    end
    m_cnt++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_1000 | ($urandom & 32'hFFF);
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, 4 * 24 - 1));
  endfunction

  // One clock: check outputs at the negedge, drive inputs, advance the model at the posedge.
  task automatic step(input bit v, input logic [7:0] d, input logic [31:0] a);
    bit rdy;
    @(negedge clock);
    check_val("rom_data", bus.rom_data, exp_rom);
    check_val("rx_ready", 32'(bus.rx_ready), 32'(m_ready()));
    check_val("cpu_enable", 32'(bus.cpu_enable), 32'(m_run()));
    check_val("load_error", 32'(bus.load_error), 32'(m_err()));
    check_val("loaded_words", 32'(bus.loaded_words), 32'(m_loaded()));
    bus.rx_valid    = v;
    bus.rx_data     = d;
    bus.rom_address = a;
    exp_rom = m_fetch(a);
    rdy = m_ready();
    @(posedge clock);
    if (v && rdy) m_accept(d);
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      int unsigned g;
      g = $urandom_range(1, 3);
      for (int unsigned i = 0; i < g; i++) step(1'b0, 8'($urandom), rnd_addr());
    end
    step(1'b1, b, rnd_addr());
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check_val("rst_loaded", 32'(bus.loaded_words), 32'd0);
    check_val("rst_load_error", 32'(bus.load_error), 32'd0);
    check_val("rst_rom_data", bus.rom_data, NOP);
    m_cnt = 0;
    m_n = -1;
    m_lo = '0;
    exp_rom = NOP;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_image(input int n, input bit gaps);
    send(8'(n), gaps);
    send(8'(n >> 8), gaps);
    for (int i = 0; i < 4 * n; i++) send(8'($urandom), gaps);
  endtask

  task automatic fetch_some(input int count);
    for (int i = 0; i < count; i++) step(1'($urandom), 8'($urandom), rnd_addr());
  endtask

  logic [7:0] t1 [10];
  logic [7:0] t5 [6];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.rom_address = '0;
    m_cnt = 0;
    m_n = -1;
    exp_rom = NOP;
    reset = 1'b1;
    #12 reset = 1'b0;

    // Directed two-word image
    do_reset();
    t1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 10; i++) send(t1[i], 1'b0);
    step(1'b0, 8'h00, 32'd0);
    #1 check_val("t1_word0", bus.rom_data, 32'h0010_0513);
    step(1'b0, 8'h00, 32'd4);
    #1 check_val("t1_word1", bus.rom_data, 32'h0020_0593);
    step(1'b0, 8'h00, 32'd8);
    #1 check_val("t2_past_end", bus.rom_data, NOP);
    step(1'b0, 8'h00, 32'h0000_1000);
    #1 check_val("t2_high_bits", bus.rom_data, NOP);
    step(1'b0, 8'h00, 32'd5);
    #1 check_val("t2_low_bits", bus.rom_data, 32'h0020_0593);
    fetch_some(20);

    // Oversized length, then trailing bytes must be refused
    do_reset();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    step(1'b0, 8'h00, 32'd0);
    #1 check_val("t3_error", 32'(bus.load_error), 32'd1);

    // Empty image
    do_reset();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    fetch_some(15);

    // Reset mid-word discards the partial data
    do_reset();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    do_reset();
    t5 = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) send(t5[i], 1'b0);
    step(1'b0, 8'h00, 32'd0);
    #1 check_val("t5_word0", bus.rom_data, 32'h0000_0013);
    check_val("t5_loaded", 32'(bus.loaded_words), 32'd1);

    // Random images with and without gaps; RUN keeps ignoring valid bytes
    for (int k = 0; k < 6; k++) begin
      do_reset();
      send_image($urandom_range(1, 20), 1'(k & 1));
      for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), rnd_addr());
    end

    // Exactly full capacity
    do_reset();
    send_image(CAP, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 32'($urandom_range(0, 4 * CAP + 16)));

    // Reset during RUN drops cpu_enable, reload from index 0
    do_reset();
    send_image(3, 1'b1);
    fetch_some(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
